pipe_mux_n: RTL and testbench



---
 rtl/mips_pipe_pkg.sv | 21 ++
 rtl/pipe_mux_sel.sv | 31 +++
 rtl/pipe_mux_n.sv | 141 ++++++++++++++
 tb/tb_pipe_mux_n.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Purpose: shared types and helpers for the pipelined selector blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pipe_pkg;

    // Largest input count the selector is intended to be built with.
    localparam int PIPE_MUX_MAX_IN = 16;

    // Occupancy of the output stage: nothing, main register only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_st_e;

    // Select width for n inputs; a 1-input or 2-input mux still needs one select bit.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_mux_sel.sv
// Purpose: combinational N:1 selector, zero output and err flag on out-of-range select.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake at this level.
// Ports: i_data (packed inputs, lane k at [k*WIDTH +: WIDTH]), i_sel (lane index),
//        o_data (selected lane or zero), o_err (i_sel >= NUM_IN).
module pipe_mux_sel
    import mips_pipe_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 2,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_err
);

    // Defaults cover the out-of-range case: no lane matches, so output stays zero.
    always_comb begin
        o_data = '0;
        o_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
                o_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_mux_n.sv
// Purpose: N-input W-bit selector with registered output and valid/ready handshake.
// Latency: 1 cycle from acceptance to out_valid/out_data.
// Backpressure: with PIPE_MUX_SKID_EN a registered in_ready backed by a skid entry;
//               otherwise in_ready = out_ready || !out_valid (combinational).
// Ports: clk, rst_n (async active-low); in_data/in_sel/in_valid/in_ready upstream;
//        out_data/out_valid/out_ready downstream; sel_err one-cycle out-of-range pulse.
// Build option: define PIPE_MUX_SKID_EN to compile in the skid register.
module pipe_mux_n
    import mips_pipe_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 2,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [WIDTH-1:0] w_sel_dat;
    logic             w_sel_err;
    logic             w_acc;
    logic             w_drain;
    logic             w_ld_m_in;
    pipe_st_e         r_state;
    pipe_st_e         w_state_nxt;
    logic [WIDTH-1:0] r_m;
    logic             r_err;
`ifdef PIPE_MUX_SKID_EN
    logic [WIDTH-1:0] r_s;
    logic             r_rdy;
    logic             w_ld_m_s;
    logic             w_ld_s;
`endif

    pipe_mux_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .i_data (in_data),
        .i_sel  (in_sel),
        .o_data (w_sel_dat),
        .o_err  (w_sel_err)
    );

    assign w_acc     = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_m;
    assign sel_err   = r_err;

`ifdef PIPE_MUX_SKID_EN
    assign in_ready = r_rdy;
`else
    assign in_ready = out_ready || !out_valid;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ld_m_in   = 1'b0;
`ifdef PIPE_MUX_SKID_EN
        w_ld_m_s    = 1'b0;
        w_ld_s      = 1'b0;
`endif
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt = ST_ONE;
                    w_ld_m_in   = 1'b1;
                end
            end
            ST_ONE: begin
`ifdef PIPE_MUX_SKID_EN
                // M is still waiting downstream: park the new value in S.
                if (w_acc && !w_drain) begin
                    w_state_nxt = ST_TWO;
                    w_ld_s      = 1'b1;
                end else
`endif
                if (w_acc) begin
                    w_ld_m_in = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
`ifdef PIPE_MUX_SKID_EN
            ST_TWO: begin
                // in_ready is low here, so only a drain can move the state.
                if (w_drain) begin
                    w_state_nxt = ST_ONE;
                    w_ld_m_s    = 1'b1;
                end
            end
`endif
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_m     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_acc && w_sel_err;
            if (w_ld_m_in) begin
                r_m <= w_sel_dat;
            end
`ifdef PIPE_MUX_SKID_EN
            else if (w_ld_m_s) begin
                r_m <= r_s;
            end
`endif
        end
    end

`ifdef PIPE_MUX_SKID_EN
    // in_ready is registered from the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s   <= '0;
            r_rdy <= 1'b1;
        end else begin
            r_rdy <= (w_state_nxt != ST_TWO);
            if (w_ld_s) begin
                r_s <= w_sel_dat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// Purpose: randomized scoreboard bench for pipe_mux_n (WIDTH=5, NUM_IN=3).
// Latency: expects each accepted value on the output one cycle after acceptance.
// Backpressure: exercises stalls, skid fill (when compiled in), throughput and async reset.
module tb_pipe_mux_n;

    localparam int WIDTH  = 5;
    localparam int NUM_IN = 3;

    logic        clk;
    logic        rst_n;
    logic [14:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;

    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    logic [4:0]  exp_q[$];

    // Monitor-side model state: transaction count held in the stage, pending error pulse.
    int          occ = 0;
    bit          exp_err = 0;
    bit          hold_chk = 0;
    logic [4:0]  hold_dat = '0;

    pipe_mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference select: shift the chosen lane down; out-of-range lanes read as zero.
    function automatic logic [4:0] ref_sel(input logic [14:0] d, input logic [1:0] s);
        logic [14:0] sh;
        if (int'(s) >= NUM_IN) return 5'd0;
        sh = d >> (WIDTH * int'(s));
        return sh[4:0];
    endfunction

    // One cycle of stimulus; the expected output is queued when the handshake accepts it.
    task automatic drive(input bit v, input logic [14:0] d, input logic [1:0] s,
                         input bit ordy, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = ordy;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(ref_sel(d, s));
    endtask

    task automatic drain_all(input string name);
        bit a;
        for (int c = 0; c < 10; c++) begin
            if (exp_q.size() == 0) break;
            drive(1'b0, 15'd0, 2'd0, 1'b1, a);
            #1;
        end
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        bit drain;
        bit acc;
        logic [4:0] e;
        if (!rst_n) begin
            occ      = 0;
            exp_err  = 0;
            hold_chk = 0;
            exp_q.delete();
        end else begin
            check("out_valid", out_valid, occ != 0);
`ifdef PIPE_MUX_SKID_EN
            check("in_ready", in_ready, occ < 2);
`else
            check("in_ready", in_ready, out_ready || (occ == 0));
`endif
            check("sel_err", sel_err, exp_err);
            if (hold_chk) check("hold_data", out_data, hold_dat);
            drain = out_valid && out_ready;
            acc   = in_valid && in_ready;
            if (drain) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
                end
                n_out++;
            end
            exp_err  = acc && (int'(in_sel) >= NUM_IN);
            occ      = occ + int'(acc) - int'(drain);
            hold_chk = out_valid && !out_ready;
            hold_dat = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a;
        int          idx;
        int          n0;
        logic [4:0]  items[4];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sel_err", sel_err, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        // Basic select: lanes {9, 17, 31}.
        drive(1'b1, {5'd9, 5'd17, 5'd31}, 2'd1, 1'b1, a);
        check("basic_acc", a, 1);
        drive(1'b1, {5'd9, 5'd17, 5'd31}, 2'd2, 1'b1, a);
        check("basic_sel1", out_data, 17);
        drive(1'b0, 15'd0, 2'd0, 1'b1, a);
        check("basic_sel2", out_data, 9);

        // Out-of-range select: zero data, one-cycle error pulse.
        drive(1'b1, {5'd9, 5'd17, 5'd31}, 2'd3, 1'b1, a);
        drive(1'b0, 15'd0, 2'd0, 1'b1, a);
        check("oor_data", out_data, 0);
        check("oor_valid", out_valid, 1);
        check("oor_err", sel_err, 1);
        drive(1'b0, 15'd0, 2'd0, 1'b1, a);
        check("oor_err_clear", sel_err, 0);

        // Back-pressure: stream 1..4 against a stalled output.
        items = '{5'd1, 5'd2, 5'd3, 5'd4};
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(idx < 4, {10'($urandom), items[idx < 4 ? idx : 3]}, 2'd0, 1'b0, a);
            if (a) idx++;
        end
`ifdef PIPE_MUX_SKID_EN
        check("bp_accepted", idx, 2);
        check("bp_in_ready", in_ready, 0);
`else
        check("bp_accepted", idx, 1);
`endif
        check("bp_hold_first", out_data, 1);
        for (int c = 0; c < 20; c++) begin
            if (idx >= 4) break;
            drive(1'b1, {10'($urandom), items[idx]}, 2'd0, 1'b1, a);
            if (a) idx++;
        end
        check("bp_all_sent", idx, 4);
        drain_all("bp_drained");

        // Randomized traffic with random stalls and selects.
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), 15'($urandom), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), a);
        end
        drain_all("rand_drained");

        // Throughput: 100 back-to-back transfers with no stall.
        #1 n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, {10'($urandom), 5'(i)}, 2'd0, 1'b1, a);
            check("tput_acc", a, 1);
        end
        drive(1'b0, 15'd0, 2'd0, 1'b1, a);
        #1 check("tput_count", n_out - n0, 100);
        drain_all("tput_drained");

        // Async reset while the stage holds data.
        drive(1'b1, {10'd0, 5'd7}, 2'd0, 1'b0, a);
        drive(1'b1, {10'd0, 5'd8}, 2'd0, 1'b0, a);
        check("ar_valid_before", out_valid, 1);
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_data", out_data, 0);
        check("ar_sel_err", sel_err, 0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check("ar_in_ready", in_ready, 1);
        drive(1'b1, {10'd0, 5'd21}, 2'd0, 1'b1, a);
        check("ar_acc", a, 1);
        drive(1'b0, 15'd0, 2'd0, 1'b1, a);
        check("ar_first_out", out_data, 21);
        check("ar_first_valid", out_valid, 1);
        drain_all("ar_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
